// File: rtl/id_stage_param.sv
// id_stage_param: RISC-V decode stage with bypassed register file, immediate generation, branch resolution and ID/EX register
module id_stage_param #(
   parameter int XLEN   = 32,
   parameter int NREG   = 32,
   parameter int CTRL_W = 8,
   localparam int RA_W  = $clog2(NREG)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_id_valid,
   input  logic [XLEN-1:0]   if_id_pc,
   input  logic [31:0]       if_id_inst,
   input  logic              wb_en,
   input  logic [RA_W-1:0]   wb_rd,
   input  logic [XLEN-1:0]   wb_data,
   input  logic [1:0]        fwd_sel1,
   input  logic [1:0]        fwd_sel2,
   input  logic [XLEN-1:0]   ex_fwd_data,
   input  logic [XLEN-1:0]   mem_fwd_data,
   input  logic [CTRL_W-1:0] ctrl_in,
   input  logic              stall,
   input  logic              flush,
   output logic              br_taken,
   output logic [XLEN-1:0]   pc_target,
   output logic              id_ex_valid,
   output logic              id_ex_illegal,
   output logic [CTRL_W-1:0] id_ex_ctrl,
   output logic [XLEN-1:0]   id_ex_pc,
   output logic [XLEN-1:0]   id_ex_data1,
   output logic [XLEN-1:0]   id_ex_data2,
   output logic [XLEN-1:0]   id_ex_imm,
   output logic [RA_W-1:0]   id_ex_rs1,
   output logic [RA_W-1:0]   id_ex_rs2,
   output logic [RA_W-1:0]   id_ex_rd,
   output logic [3:0]        id_ex_func
);
   logic [6:0]        opc;
   logic [2:0]        f3;
   logic [4:0]        rs1_f, rs2_f, rd_f;
   logic [RA_W-1:0]   rs1, rs2, rd;
   logic [XLEN-1:0]   rf_q [NREG];
   logic [XLEN-1:0]   rf1, rf2, d1, d2, imm, sum_pc, sum_jr;
   logic [31:0]       imm32;
   logic              is_i, is_s, is_b, is_u, is_j, is_r, is_jal, is_jalr;
   logic              fld_bad, illegal, eq, lt, ltu, cond;
   logic              valid_q, ill_q;
   logic [CTRL_W-1:0] ctrl_q;
   logic [XLEN-1:0]   pc_q, d1_q, d2_q, imm_q;
   logic [RA_W-1:0]   rs1_q, rs2_q, rd_q;
   logic [3:0]        func_q;

   assign opc   = if_id_inst[6:0];
   assign f3    = if_id_inst[14:12];
   assign rs1_f = if_id_inst[19:15];
   assign rs2_f = if_id_inst[24:20];
   assign rd_f  = if_id_inst[11:7];
   assign rs1   = rs1_f[RA_W-1:0];
   assign rs2   = rs2_f[RA_W-1:0];
   assign rd    = rd_f[RA_W-1:0];
   // with 16 registers any field naming x16..x31 is not encodable
   assign fld_bad = (NREG == 16) && (rs1_f[4] | rs2_f[4] | rd_f[4]);

   always_ff @(posedge clk)
      if (reset)
         for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
      else if (wb_en && wb_rd != '0)
         rf_q[wb_rd] <= wb_data;

   assign rf1 = (rs1 == '0) ? '0 : (wb_en && wb_rd == rs1) ? wb_data : rf_q[rs1];
   assign rf2 = (rs2 == '0) ? '0 : (wb_en && wb_rd == rs2) ? wb_data : rf_q[rs2];
   assign d1  = (fwd_sel1 == 2'b01) ? ex_fwd_data : (fwd_sel1 == 2'b10) ? mem_fwd_data : rf1;
   assign d2  = (fwd_sel2 == 2'b01) ? ex_fwd_data : (fwd_sel2 == 2'b10) ? mem_fwd_data : rf2;

   assign is_jal  = opc == 7'b1101111;
   assign is_jalr = opc == 7'b1100111;
   assign is_i    = opc == 7'b0000011 || opc == 7'b0010011 || is_jalr;
   assign is_s    = opc == 7'b0100011;
   assign is_b    = opc == 7'b1100011;
   assign is_u    = opc == 7'b0110111 || opc == 7'b0010111;
   assign is_j    = is_jal;
   assign is_r    = opc == 7'b0110011;

   assign imm32 = is_i ? {{20{if_id_inst[31]}}, if_id_inst[31:20]} :
                  is_s ? {{20{if_id_inst[31]}}, if_id_inst[31:25], if_id_inst[11:7]} :
                  is_b ? {{20{if_id_inst[31]}}, if_id_inst[7], if_id_inst[30:25], if_id_inst[11:8], 1'b0} :
                  is_u ? {if_id_inst[31:12], 12'b0} :
                  is_j ? {{12{if_id_inst[31]}}, if_id_inst[19:12], if_id_inst[20], if_id_inst[30:21], 1'b0} :
                  32'b0;
   assign imm     = {{(XLEN-31){imm32[31]}}, imm32[30:0]};
   assign illegal = fld_bad | ~(is_i | is_s | is_b | is_u | is_j | is_r) | (is_b & f3[2:1] == 2'b01);

   assign eq   = d1 == d2;
   assign lt   = $signed(d1) < $signed(d2);
   assign ltu  = d1 < d2;
   // funct3[0] inverts the base test; 010/011 never take
   assign cond = f3[2] ? ((f3[1] ? ltu : lt) ^ f3[0]) : (~f3[1] & (eq ^ f3[0]));

   assign sum_pc    = if_id_pc + imm;
   assign sum_jr    = d1 + imm;
   assign br_taken  = if_id_valid & ~stall & ~flush & (is_jal | is_jalr | (is_b & cond));
   assign pc_target = is_jalr ? {sum_jr[XLEN-1:1], 1'b0} : sum_pc;

   always_ff @(posedge clk)
      if (reset) begin
         valid_q <= 1'b0;
         ill_q   <= 1'b0;
         ctrl_q  <= '0;
         pc_q    <= '0;
         d1_q    <= '0;
         d2_q    <= '0;
         imm_q   <= '0;
         rs1_q   <= '0;
         rs2_q   <= '0;
         rd_q    <= '0;
         func_q  <= '0;
      end else if (flush | stall) begin
         valid_q <= 1'b0;
         ill_q   <= 1'b0;
         ctrl_q  <= '0;
      end else begin
         valid_q <= if_id_valid;
         ill_q   <= if_id_valid & illegal;
         ctrl_q  <= if_id_valid ? ctrl_in : '0;
         pc_q    <= if_id_pc;
         d1_q    <= d1;
         d2_q    <= d2;
         imm_q   <= imm;
         rs1_q   <= rs1;
         rs2_q   <= rs2;
         rd_q    <= rd;
         func_q  <= {if_id_inst[30], f3};
      end

   assign id_ex_valid   = valid_q;
   assign id_ex_illegal = ill_q;
   assign id_ex_ctrl    = ctrl_q;
   assign id_ex_pc      = pc_q;
   assign id_ex_data1   = d1_q;
   assign id_ex_data2   = d2_q;
   assign id_ex_imm     = imm_q;
   assign id_ex_rs1     = rs1_q;
   assign id_ex_rs2     = rs2_q;
   assign id_ex_rd      = rd_q;
   assign id_ex_func    = func_q;
endmodule

// File: tb/tb_id_stage_param.sv
// tb_id_stage_param: random and directed checks of id_stage_param against an encoder-driven reference model
module tb_id_stage_param;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, if_id_valid, wb_en, stall, flush;
   logic [31:0] if_id_pc, if_id_inst, wb_data, ex_fwd_data, mem_fwd_data;
   logic [4:0]  wb_rd;
   logic [1:0]  fwd_sel1, fwd_sel2;
   logic [7:0]  ctrl_in;
   logic        br_taken, id_ex_valid, id_ex_illegal;
   logic [31:0] pc_target, id_ex_pc, id_ex_data1, id_ex_data2, id_ex_imm;
   logic [7:0]  id_ex_ctrl;
   logic [4:0]  id_ex_rs1, id_ex_rs2, id_ex_rd;
   logic [3:0]  id_ex_func;

   id_stage_param dut (
      .clk(clk), .reset(reset), .if_id_valid(if_id_valid), .if_id_pc(if_id_pc), .if_id_inst(if_id_inst),
      .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2),
      .ex_fwd_data(ex_fwd_data), .mem_fwd_data(mem_fwd_data), .ctrl_in(ctrl_in), .stall(stall), .flush(flush),
      .br_taken(br_taken), .pc_target(pc_target), .id_ex_valid(id_ex_valid), .id_ex_illegal(id_ex_illegal),
      .id_ex_ctrl(id_ex_ctrl), .id_ex_pc(id_ex_pc), .id_ex_data1(id_ex_data1), .id_ex_data2(id_ex_data2),
      .id_ex_imm(id_ex_imm), .id_ex_rs1(id_ex_rs1), .id_ex_rs2(id_ex_rs2), .id_ex_rd(id_ex_rd), .id_ex_func(id_ex_func)
   );

   logic [31:0] inst64;
   logic        br64, v64, ill64;
   logic [63:0] tgt64, pc64, da64, db64, imm64;
   logic [7:0]  ctrl64;
   logic [4:0]  rs1_64, rs2_64, rd64;
   logic [3:0]  func64;

   id_stage_param #(.XLEN(64)) dut64 (
      .clk(clk), .reset(reset), .if_id_valid(1'b1), .if_id_pc(64'h0), .if_id_inst(inst64),
      .wb_en(1'b0), .wb_rd(5'd0), .wb_data(64'h0), .fwd_sel1(2'b00), .fwd_sel2(2'b00),
      .ex_fwd_data(64'h0), .mem_fwd_data(64'h0), .ctrl_in(8'h0), .stall(1'b0), .flush(1'b0),
      .br_taken(br64), .pc_target(tgt64), .id_ex_valid(v64), .id_ex_illegal(ill64),
      .id_ex_ctrl(ctrl64), .id_ex_pc(pc64), .id_ex_data1(da64), .id_ex_data2(db64),
      .id_ex_imm(imm64), .id_ex_rs1(rs1_64), .id_ex_rs2(rs2_64), .id_ex_rd(rd64), .id_ex_func(func64)
   );

   logic [31:0] inst16, tgt16, pc16, da16, db16, imm16;
   logic        br16, v16, ill16;
   logic [7:0]  ctrl16;
   logic [3:0]  rs1_16, rs2_16, rd16, func16;

   id_stage_param #(.NREG(16)) dut16 (
      .clk(clk), .reset(reset), .if_id_valid(1'b1), .if_id_pc(32'h0), .if_id_inst(inst16),
      .wb_en(1'b0), .wb_rd(4'd0), .wb_data(32'h0), .fwd_sel1(2'b00), .fwd_sel2(2'b00),
      .ex_fwd_data(32'h0), .mem_fwd_data(32'h0), .ctrl_in(8'h0), .stall(1'b0), .flush(1'b0),
      .br_taken(br16), .pc_target(tgt16), .id_ex_valid(v16), .id_ex_illegal(ill16),
      .id_ex_ctrl(ctrl16), .id_ex_pc(pc16), .id_ex_data1(da16), .id_ex_data2(db16),
      .id_ex_imm(imm16), .id_ex_rs1(rs1_16), .id_ex_rs2(rs2_16), .id_ex_rd(rd16), .id_ex_func(func16)
   );

   int n_chk = 0, n_fail = 0;
   int kind;
   logic [31:0] exp_imm;
   logic [31:0] rf [32];
   logic        e_valid, e_ill;
   logic [7:0]  e_ctrl;
   logic [31:0] e_pc, e_d1, e_d2, e_imm;
   logic [4:0]  e_rs1, e_rs2, e_rd;
   logic [3:0]  e_func;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // kinds: 0 R, 1 load, 2 op-imm, 3 jalr, 4 store, 5 branch, 6 lui, 7 auipc, 8 jal, 9 undefined opcode
   function automatic logic [31:0] enc(int k, logic [4:0] r1, logic [4:0] r2, logic [4:0] d, logic [2:0] f, int v, logic [6:0] op);
      case (k)
         0: return {v[31:25], r2, r1, f, d, 7'b0110011};
         1: return {v[11:0], r1, f, d, 7'b0000011};
         2: return {v[11:0], r1, f, d, 7'b0010011};
         3: return {v[11:0], r1, f, d, 7'b1100111};
         4: return {v[11:5], r2, r1, f, v[4:0], 7'b0100011};
         5: return {v[12], v[10:5], r2, r1, f, v[4:1], v[11], 7'b1100011};
         6: return {v[31:12], d, 7'b0110111};
         7: return {v[31:12], d, 7'b0010111};
         8: return {v[20], v[10:1], v[11], v[19:12], d, 7'b1101111};
         default: return {7'b0, r2, r1, f, d, op};
      endcase
   endfunction

   task automatic set_inst(input int k, input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] d,
                           input logic [2:0] f, input int v, input logic [6:0] op);
      kind       = k;
      if_id_inst = enc(k, r1, r2, d, f, v, op);
      exp_imm    = (k == 0 || k == 9) ? 32'h0 : 32'(v);
   endtask

   function automatic logic [31:0] rdrf(logic [4:0] r);
      return (r == 0) ? 32'h0 : (wb_en && wb_rd == r) ? wb_data : rf[r];
   endfunction

   function automatic logic [31:0] fwd(logic [1:0] s, logic [31:0] r);
      return (s == 2'b01) ? ex_fwd_data : (s == 2'b10) ? mem_fwd_data : r;
   endfunction

   function automatic bit taken(logic [2:0] f, logic [31:0] a, logic [31:0] b);
      case (f)
         3'b000: return a == b;
         3'b001: return a != b;
         3'b100: return $signed(a) < $signed(b);
         3'b101: return $signed(a) >= $signed(b);
         3'b110: return a < b;
         3'b111: return a >= b;
         default: return 1'b0;
      endcase
   endfunction

   task automatic cycle();
      logic [31:0] d1, d2, tgt;
      logic [2:0]  f;
      logic        ill, tk;
      #1;
      f   = if_id_inst[14:12];
      d1  = fwd(fwd_sel1, rdrf(if_id_inst[19:15]));
      d2  = fwd(fwd_sel2, rdrf(if_id_inst[24:20]));
      ill = kind == 9 || (kind == 5 && (f == 3'b010 || f == 3'b011));
      tk  = if_id_valid && !stall && !flush && (kind == 3 || kind == 8 || (kind == 5 && taken(f, d1, d2)));
      tgt = (kind == 3) ? ((d1 + exp_imm) & 32'hFFFF_FFFE) : if_id_pc + exp_imm;
      if (!reset) begin
         chk("br_taken", br_taken, tk);
         if (tk) chk("pc_target", pc_target, tgt);
      end
      if (reset) begin
         {e_valid, e_ill, e_ctrl, e_pc, e_d1, e_d2, e_imm, e_rs1, e_rs2, e_rd, e_func} = '0;
         foreach (rf[i]) rf[i] = 32'h0;
      end else begin
         if (flush || stall) begin
            e_valid = 1'b0; e_ill = 1'b0; e_ctrl = 8'h0;
         end else begin
            e_valid = if_id_valid;
            e_ill   = if_id_valid & ill;
            e_ctrl  = if_id_valid ? ctrl_in : 8'h0;
            e_pc    = if_id_pc;
            e_d1    = d1;
            e_d2    = d2;
            e_imm   = exp_imm;
            e_rs1   = if_id_inst[19:15];
            e_rs2   = if_id_inst[24:20];
            e_rd    = if_id_inst[11:7];
            e_func  = {if_id_inst[30], f};
         end
         if (wb_en && wb_rd != 0) rf[wb_rd] = wb_data;
      end
      @(posedge clk);
      #1;
      chk("id_ex_valid", id_ex_valid, e_valid);
      chk("id_ex_illegal", id_ex_illegal, e_ill);
      chk("id_ex_ctrl", id_ex_ctrl, e_ctrl);
      chk("id_ex_pc", id_ex_pc, e_pc);
      chk("id_ex_data1", id_ex_data1, e_d1);
      chk("id_ex_data2", id_ex_data2, e_d2);
      chk("id_ex_imm", id_ex_imm, e_imm);
      chk("id_ex_rs1", id_ex_rs1, e_rs1);
      chk("id_ex_rs2", id_ex_rs2, e_rs2);
      chk("id_ex_rd", id_ex_rd, e_rd);
      chk("id_ex_func", id_ex_func, e_func);
      @(negedge clk);
   endtask

   task automatic wr(input logic [4:0] r, input logic [31:0] v);
      if_id_valid = 1'b0; wb_en = 1'b1; wb_rd = r; wb_data = v;
      cycle();
      wb_en = 1'b0;
   endtask

   function automatic logic [31:0] rnd_val();
      return ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
   endfunction

   task automatic rand_in();
      int k, v;
      logic [6:0] op;
      reset       = $urandom_range(0, 63) == 0;
      if_id_valid = $urandom_range(0, 7) != 0;
      stall       = $urandom_range(0, 7) == 0;
      flush       = $urandom_range(0, 9) == 0;
      if_id_pc    = $urandom & 32'hFFFF_FFFC;
      wb_en       = 1'($urandom);
      wb_rd       = 5'($urandom);
      wb_data     = rnd_val();
      fwd_sel1    = 2'($urandom);
      fwd_sel2    = 2'($urandom);
      ex_fwd_data = rnd_val();
      mem_fwd_data = rnd_val();
      ctrl_in     = 8'($urandom);
      k = $urandom_range(0, 9);
      case (k)
         1, 2, 3, 4: v = int'($urandom_range(0, 4095)) - 2048;
         5:          v = 2 * (int'($urandom_range(0, 4095)) - 2048);
         6, 7:       v = int'($urandom_range(0, 1048575)) << 12;
         8:          v = 2 * (int'($urandom_range(0, 1048575)) - 524288);
         0:          v = int'($urandom);
         default:    v = 0;
      endcase
      do op = 7'($urandom);
      while (op inside {7'b0000011, 7'b0010011, 7'b1100111, 7'b0100011, 7'b1100011,
                        7'b0110111, 7'b0010111, 7'b1101111, 7'b0110011});
      set_inst(k, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), v, op);
   endtask

   initial begin
      reset = 1'b1; if_id_valid = 1'b1; if_id_pc = 32'h0; wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'h1234;
      fwd_sel1 = 2'b00; fwd_sel2 = 2'b00; ex_fwd_data = 32'h0; mem_fwd_data = 32'h0;
      ctrl_in = 8'hA5; stall = 1'b0; flush = 1'b0;
      set_inst(0, 5'd5, 5'd0, 5'd1, 3'b000, 0, 7'h0);
      inst64 = {20'h80000, 5'd1, 7'b0110111};
      inst16 = enc(2, 5'd17, 5'd0, 5'd1, 3'b000, 5, 7'h0);
      @(negedge clk);
      cycle();
      cycle();
      reset = 1'b0; wb_en = 1'b0;
      cycle();
      chk("x5_after_reset", id_ex_data1, 32'h0);
      chk("xlen64_lui_imm", imm64, 64'hFFFF_FFFF_8000_0000);
      chk("nreg16_rs1_17_illegal", ill16, 1'b1);
      inst16 = enc(2, 5'd3, 5'd0, 5'd1, 3'b000, 5, 7'h0);
      wb_en = 1'b1; wb_rd = 5'd3; wb_data = 32'hDEAD_BEEF;
      set_inst(0, 5'd3, 5'd0, 5'd1, 3'b000, 0, 7'h0);
      cycle();
      chk("write_through", id_ex_data1, 32'hDEAD_BEEF);
      chk("nreg16_rs1_3_legal", ill16, 1'b0);
      wr(5'd0, 32'h55);
      if_id_valid = 1'b1;
      set_inst(0, 5'd0, 5'd0, 5'd1, 3'b000, 0, 7'h0);
      cycle();
      chk("x0_reads_zero", id_ex_data1, 32'h0);
      wr(5'd1, 32'hFFFF_FFFF);
      wr(5'd2, 32'h1);
      if_id_valid = 1'b1; if_id_pc = 32'h100;
      set_inst(5, 5'd1, 5'd2, 5'd0, 3'b100, -8, 7'h0);
      #1 chk("blt_taken", br_taken, 1'b1);
      chk("blt_target", pc_target, 32'hF8);
      cycle();
      set_inst(5, 5'd1, 5'd2, 5'd0, 3'b110, -8, 7'h0);
      #1 chk("bltu_not_taken", br_taken, 1'b0);
      cycle();
      fwd_sel2 = 2'b01; ex_fwd_data = 32'hFFFF_FFFF;
      set_inst(5, 5'd1, 5'd2, 5'd0, 3'b001, -8, 7'h0);
      #1 chk("bne_fwd_not_taken", br_taken, 1'b0);
      cycle();
      fwd_sel2 = 2'b00;
      wr(5'd1, 32'h1003);
      if_id_valid = 1'b1;
      set_inst(3, 5'd1, 5'd0, 5'd5, 3'b000, 4, 7'h0);
      #1 chk("jalr_target", pc_target, 32'h1006);
      cycle();
      if_id_pc = 32'h200;
      set_inst(8, 5'd0, 5'd0, 5'd1, 3'b000, -512, 7'h0);
      #1 chk("jal_target", pc_target, 32'h0);
      chk("jal_taken", br_taken, 1'b1);
      cycle();
      stall = 1'b1;
      set_inst(1, 5'd2, 5'd0, 5'd4, 3'b010, -4, 7'h0);
      #1 chk("stall_no_branch", br_taken, 1'b0);
      cycle();
      chk("stall_bubble", id_ex_valid, 1'b0);
      flush = 1'b1;
      cycle();
      chk("stall_flush_bubble", id_ex_ctrl, 8'h0);
      stall = 1'b0; flush = 1'b0;
      cycle();
      chk("lw_rd", id_ex_rd, 5'd4);
      chk("lw_imm", id_ex_imm, 32'hFFFF_FFFC);
      set_inst(9, 5'd1, 5'd2, 5'd3, 3'b000, 0, 7'h7F);
      cycle();
      chk("op7f_illegal", id_ex_illegal, 1'b1);
      chk("op7f_imm", id_ex_imm, 32'h0);
      for (int n = 0; n < 3000; n++) begin
         rand_in();
         cycle();
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
